// File: rtl/adi3w_spi_responder.sv
// ADI 3-wire SPI device-side responder: oversampled SCLK/CSB/SDIO, 16-bit instruction,
// byte-wide register file with write strobes and a read-only chip ID at address 1.
module adi3w_spi_responder #(
  parameter int unsigned aw      = 5,
  parameter logic [7:0]  chip_id = 8'h82
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sclk,
  input  logic          csb,
  input  logic          sdi,
  output logic          sdo,
  output logic          sdo_oe,
  output logic          reg_we,
  output logic [aw-1:0] reg_addr,
  output logic [7:0]    reg_wdata,
  output logic          busy,
  output logic          frame_err
);

  localparam int unsigned NREG = 1 << aw;
  localparam int unsigned IW   = 16;
  localparam int unsigned BW   = 8;
  localparam logic [aw-1:0] ID_ADDR = aw'(1);

  typedef enum logic [2:0] {IDLE, INSTR, WDATA, RDATA, DONE} state_t;

  // Pad synchronizers plus history flops for edge detection
  logic sclk_m, sclk_s, sclk_h;
  logic csb_m, csb_s, csb_h;
  logic sdi_m, sdi_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_m <= 1'b0; sclk_s <= 1'b0; sclk_h <= 1'b0;
      csb_m  <= 1'b1; csb_s  <= 1'b1; csb_h  <= 1'b1;
      sdi_m  <= 1'b0; sdi_s  <= 1'b0;
    end else begin
      sclk_m <= sclk; sclk_s <= sclk_m; sclk_h <= sclk_s;
      csb_m  <= csb;  csb_s  <= csb_m;  csb_h  <= csb_s;
      sdi_m  <= sdi;  sdi_s  <= sdi_m;
    end
  end

  logic rise, fall, csb_fall;
  assign rise     = sclk_s & ~sclk_h;
  assign fall     = ~sclk_s & sclk_h;
  assign csb_fall = ~csb_s & csb_h;

  state_t          state, state_nxt;
  logic [3:0]      bit_cnt, bit_cnt_nxt;
  logic [IW-2:0]   sr, sr_nxt;
  logic [BW-1:0]   rd_sr, rd_sr_nxt;
  logic [aw-1:0]   addr, addr_nxt;
  logic [1:0]      left, left_nxt;
  logic            sdo_nxt, sdo_oe_nxt, reg_we_nxt, busy_nxt, frame_err_nxt;
  logic [aw-1:0]   reg_addr_nxt;
  logic [BW-1:0]   reg_wdata_nxt;

  logic [BW-1:0]   reg_file [NREG];
  logic [IW-1:0]   shift_in;
  logic [aw-1:0]   rd_addr_c;
  logic [BW-1:0]   rd_data_c;
  logic            wr_en_c;

  assign shift_in  = {sr, sdi_s};
  // Next read byte: the instruction's start address on entry, else the decremented address
  assign rd_addr_c = (state == INSTR) ? shift_in[aw-1:0] : addr - aw'(1);
  assign rd_data_c = (rd_addr_c == ID_ADDR) ? chip_id : reg_file[rd_addr_c];

  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    sr_nxt        = sr;
    rd_sr_nxt     = rd_sr;
    addr_nxt      = addr;
    left_nxt      = left;
    sdo_nxt       = sdo;
    sdo_oe_nxt    = sdo_oe;
    reg_we_nxt    = 1'b0;
    reg_addr_nxt  = reg_addr;
    reg_wdata_nxt = reg_wdata;
    frame_err_nxt = 1'b0;
    wr_en_c       = 1'b0;

    // CSB deassertion overrides any SCLK edge in the same cycle
    if (state != IDLE && csb_s) begin
      state_nxt     = IDLE;
      sdo_oe_nxt    = 1'b0;
      bit_cnt_nxt   = '0;
      frame_err_nxt = (bit_cnt[2:0] != 3'd0);
    end else begin
      case (state)
        IDLE: begin
          if (csb_fall) begin
            state_nxt   = INSTR;
            bit_cnt_nxt = '0;
            sr_nxt      = '0;
          end
        end
        INSTR: begin
          if (rise) begin
            sr_nxt      = shift_in[IW-2:0];
            bit_cnt_nxt = bit_cnt + 4'd1;
            if (bit_cnt == 4'd15) begin
              bit_cnt_nxt = '0;
              left_nxt    = shift_in[14:13];
              addr_nxt    = shift_in[aw-1:0];
              if (shift_in[15]) begin
                state_nxt  = RDATA;
                rd_sr_nxt  = rd_data_c;
                sdo_oe_nxt = 1'b1;
              end else begin
                state_nxt  = WDATA;
              end
            end
          end
        end
        WDATA: begin
          if (rise) begin
            sr_nxt      = shift_in[IW-2:0];
            bit_cnt_nxt = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bit_cnt_nxt = '0;
              if (addr != ID_ADDR) begin
                wr_en_c       = 1'b1;
                reg_we_nxt    = 1'b1;
                reg_addr_nxt  = addr;
                reg_wdata_nxt = shift_in[BW-1:0];
              end
              addr_nxt = addr - aw'(1);
              left_nxt = left - 2'd1;
              if (left == 2'd0) state_nxt = DONE;
            end
          end
        end
        RDATA: begin
          if (rise) begin
            bit_cnt_nxt = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bit_cnt_nxt = '0;
              addr_nxt    = rd_addr_c;
              rd_sr_nxt   = rd_data_c;
              left_nxt    = left - 2'd1;
              if (left == 2'd0) begin
                state_nxt  = DONE;
                sdo_oe_nxt = 1'b0;
              end
            end
          end else if (fall) begin
            sdo_nxt   = rd_sr[BW-1];
            rd_sr_nxt = {rd_sr[BW-2:0], 1'b0};
          end
        end
        DONE: begin
          sdo_oe_nxt = 1'b0;
        end
        default: state_nxt = IDLE;
      endcase
    end

    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      sr        <= '0;
      rd_sr     <= '0;
      addr      <= '0;
      left      <= '0;
      sdo       <= 1'b0;
      sdo_oe    <= 1'b0;
      reg_we    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      sr        <= sr_nxt;
      rd_sr     <= rd_sr_nxt;
      addr      <= addr_nxt;
      left      <= left_nxt;
      sdo       <= sdo_nxt;
      sdo_oe    <= sdo_oe_nxt;
      reg_we    <= reg_we_nxt;
      reg_addr  <= reg_addr_nxt;
      reg_wdata <= reg_wdata_nxt;
      busy      <= busy_nxt;
      frame_err <= frame_err_nxt;
    end
  end

  // Register file; entry 1 is never written since reads there return chip_id
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) reg_file[i] <= '0;
    end else if (wr_en_c) begin
      reg_file[addr] <= shift_in[BW-1:0];
    end
  end

endmodule

// File: tb/tb_adi3w_spi_responder.sv
// Scoreboarded bench for adi3w_spi_responder: SPI master model at 8x oversampling,
// register-file model, write-strobe and read-byte scoreboards.
module tb_adi3w_spi_responder;

  localparam int unsigned HALF    = 4;
  localparam logic [7:0]  CHIP_ID = 8'h82;

  typedef struct packed {
    logic [4:0] a;
    logic [7:0] d;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst_n, sclk, csb, sdi;
  logic       sdo, sdo_oe, reg_we, busy, frame_err;
  logic [4:0] reg_addr;
  logic [7:0] reg_wdata;

  adi3w_spi_responder dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .csb(csb), .sdi(sdi),
    .sdo(sdo), .sdo_oe(sdo_oe), .reg_we(reg_we), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_pass   = 0;
  int         we_cnt   = 0;
  int         fe_cnt   = 0;
  int         oe_cnt   = 0;
  logic       prev_we  = 1'b0;
  logic [7:0] mem [32];
  wr_t        wq [$];
  logic [7:0] rq [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Write-strobe scoreboard and pulse counters, sampled on the inactive edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (reg_we) begin
        we_cnt++;
        check("we_width", 32'(prev_we), 32'd0);
        if (wq.size() == 0) begin
          check("we_unexpected", 32'd1, 32'd0);
        end else begin
          wr_t e;
          e = wq.pop_front();
          check("we_addr", 32'(reg_addr), 32'(e.a));
          check("we_data", 32'(reg_wdata), 32'(e.d));
        end
      end
      if (frame_err) fe_cnt++;
      if (sdo_oe) oe_cnt++;
      prev_we <= reg_we;
    end
  end

  // One SCLK period: drive sdi with sclk low, sample sdo just before the rise
  task automatic clk_bit(input logic b, output logic s);
    sdi = b;
    repeat (HALF) @(negedge clk);
    s = sdo;
    sclk = 1'b1;
    repeat (HALF) @(negedge clk);
    sclk = 1'b0;
  endtask

  task automatic xfer(input logic rd, input int nb, input logic [12:0] a,
                      input logic [31:0] wd, input int abort_bits, input int extra);
    logic [15:0] ins;
    logic [4:0]  ma;
    logic [7:0]  d, got;
    logic        bitv;
    int          we0, oe0, fe0, exp_we;
    ins    = {rd, 2'(nb - 1), a};
    ma     = a[4:0];
    we0    = we_cnt;
    oe0    = oe_cnt;
    fe0    = fe_cnt;
    exp_we = 0;
    csb = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 15; i >= 0; i--) clk_bit(ins[i], bitv);
    for (int b = 0; b < nb; b++) begin
      d = wd[31 - 8*b -: 8];
      if (rd) begin
        rq.push_back((ma == 5'd1) ? CHIP_ID : mem[ma]);
        got = '0;
        for (int i = 7; i >= 0; i--) begin
          clk_bit(1'b0, bitv);
          got = {got[6:0], bitv};
        end
        check("rd_byte", 32'(got), 32'(rq.pop_front()));
      end else if (abort_bits != 0) begin
        for (int i = 7; i >= 8 - abort_bits; i--) clk_bit(d[i], bitv);
        break;
      end else begin
        if (ma != 5'd1) begin
          mem[ma] = d;
          wq.push_back({ma, d});
          exp_we++;
        end
        for (int i = 7; i >= 0; i--) clk_bit(d[i], bitv);
      end
      ma = ma - 5'd1;
    end
    for (int i = 0; i < extra; i++) clk_bit(1'b1, bitv);
    repeat (4) @(negedge clk);
    if (extra != 0) begin
      check("overrun_oe", 32'(sdo_oe), 32'd0);
      check("overrun_busy", 32'(busy), 32'd1);
    end
    csb = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    repeat (4) @(negedge clk);
    check("we_count", 32'(we_cnt - we0), 32'(exp_we));
    check("oe_cycles", 32'(oe_cnt - oe0), rd ? 32'(nb * 16 * HALF) : 32'd0);
    check("frame_err", 32'(fe_cnt - fe0), (abort_bits != 0) ? 32'd1 : 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    rst_n = 1'b0; sclk = 1'b0; csb = 1'b1; sdi = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    check("rst_sdo",       32'(sdo),       32'd0);
    check("rst_sdo_oe",    32'(sdo_oe),    32'd0);
    check("rst_reg_we",    32'(reg_we),    32'd0);
    check("rst_reg_addr",  32'(reg_addr),  32'd0);
    check("rst_reg_wdata", 32'(reg_wdata), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);

    xfer(1'b1, 1, 13'h0005, 32'h0, 0, 0);              // reset value of addr 5
    xfer(1'b0, 1, 13'h0005, 32'h5500_0000, 0, 0);      // single-byte write
    xfer(1'b1, 1, 13'h0005, 32'h0, 0, 0);              // readback 0x55
    xfer(1'b1, 1, 13'h0001, 32'h0, 0, 0);              // chip ID
    xfer(1'b0, 3, 13'h0001, 32'hA1B2_C300, 0, 0);      // wrap 1 -> 0 -> 31
    xfer(1'b1, 3, 13'h0001, 32'h0, 0, 0);
    xfer(1'b0, 1, 13'h0007, 32'h3C00_0000, 0, 0);
    xfer(1'b0, 1, 13'h0007, 32'hF000_0000, 4, 0);      // aborted after 4 data bits
    xfer(1'b1, 1, 13'h0007, 32'h0, 0, 0);
    xfer(1'b1, 1, 13'h0005, 32'h0, 0, 8);              // overrun with 8 extra SCLKs
    xfer(1'b0, 4, 13'h1FE3, 32'h1122_3344, 0, 0);      // aliased high address bits
    xfer(1'b1, 4, 13'h0003, 32'h0, 0, 0);

    for (int t = 0; t < 40; t++) begin
      xfer(1'($urandom_range(0, 1)), int'($urandom_range(1, 4)), 13'($urandom),
           $urandom, 0, 0);
    end

    check("wq_drained", 32'(wq.size()), 32'd0);
    check("rq_drained", 32'(rq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
